// File: rtl/load_queue.sv
// ----------------------------------------------------------------------------
// load_queue
//
// Load queue and data-memory sequencer. Buffers computed load addresses in
// program order, issues them one at a time to a fixed-latency data BRAM,
// extracts and sign/zero-extends the addressed byte, halfword or word, and
// holds the result on the CDB until the arbiter grants it.
//
// Parameters:
//   DEPTH        queue entries (power of two, >= 2)
//   TAG_W        ROB tag width
//   MEM_LATENCY  BRAM read latency in cycles (>= 1)
//
// Ports:
//   clk_in          core clock
//   rst_n_in        asynchronous active-low reset
//   flush_in        mispredict flush, drops queued and in-flight loads
//   req_valid_in    load request valid
//   req_ready_out   queue can accept a request (decoded from the pointers)
//   req_addr_in     effective byte address
//   req_funct3_in   RV32I load funct3
//   req_tag_in      destination ROB tag
//   mem_en_out      BRAM read enable, one-cycle pulse per issued load
//   mem_addr_out    BRAM word address (addr[31:2]), held after the pulse
//   mem_rdata_in    BRAM read data
//   cdb_valid_out   result valid
//   cdb_ready_in    CDB grant
//   cdb_tag_out     result ROB tag
//   cdb_data_out    extended load data
//   cdb_exc_out     misaligned-load flag
//
// Build option:
//   LOAD_MISALIGN_CHECK_EN  when defined, misaligned halfword/word loads and
//                           the reserved funct3 codes 011/110/111 bypass the
//                           BRAM and complete with cdb_exc_out=1 and zero
//                           data. When undefined, cdb_exc_out is tied to 0
//                           and misaligned loads read the containing word.
// ----------------------------------------------------------------------------
module load_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             flush_in,
    input  logic             req_valid_in,
    output logic             req_ready_out,
    input  logic [31:0]      req_addr_in,
    input  logic [2:0]       req_funct3_in,
    input  logic [TAG_W-1:0] req_tag_in,
    output logic             mem_en_out,
    output logic [29:0]      mem_addr_out,
    input  logic [31:0]      mem_rdata_in,
    output logic             cdb_valid_out,
    input  logic             cdb_ready_in,
    output logic [TAG_W-1:0] cdb_tag_out,
    output logic [31:0]      cdb_data_out,
    output logic             cdb_exc_out
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    // Byte/halfword/word extraction with RV32I sign/zero extension.
    // Reserved funct3 codes fall through to a full-word load.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

`ifdef LOAD_MISALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [1:0] off,
                                           input logic [2:0] f3);
        logic m;
        case (f3)
            3'b000, 3'b100: m = 1'b0;
            3'b001, 3'b101: m = off[0];
            3'b010:         m = (off != 2'd0);
            default:        m = 1'b1;
        endcase
        return m;
    endfunction
`endif

    // Queue storage (data only, no reset needed)
    logic [31:0]      fifo_addr_q [DEPTH];
    logic [2:0]       fifo_f3_q   [DEPTH];
    logic [TAG_W-1:0] fifo_tag_q  [DEPTH];

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       act_off_q, act_off_d;
    logic [2:0]       act_f3_q, act_f3_d;
    logic [TAG_W-1:0] act_tag_q, act_tag_d;
    logic             mem_en_q, mem_en_d;
    logic [29:0]      mem_addr_q, mem_addr_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [31:0]      cdb_data_q, cdb_data_d;
`ifdef LOAD_MISALIGN_CHECK_EN
    logic             cdb_exc_q, cdb_exc_d;
`endif

    logic             full;
    logic             empty;
    logic             enq;
    logic             issue;
    logic [31:0]      head_addr;
    logic [2:0]       head_f3;
    logic [TAG_W-1:0] head_tag;

    // The extra pointer bit distinguishes full (wrap bits differ) from empty.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign enq   = req_valid_in && !full && !flush_in;

    assign head_addr = fifo_addr_q[rd_ptr_q[AW-1:0]];
    assign head_f3   = fifo_f3_q[rd_ptr_q[AW-1:0]];
    assign head_tag  = fifo_tag_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_in) begin
        if (enq) begin
            fifo_addr_q[wr_ptr_q[AW-1:0]] <= req_addr_in;
            fifo_f3_q[wr_ptr_q[AW-1:0]]   <= req_funct3_in;
            fifo_tag_q[wr_ptr_q[AW-1:0]]  <= req_tag_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        act_off_d   = act_off_q;
        act_f3_d    = act_f3_q;
        act_tag_d   = act_tag_q;
        mem_en_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
`ifdef LOAD_MISALIGN_CHECK_EN
        cdb_exc_d   = cdb_exc_q;
`endif
        issue       = 1'b0;

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                issue = !empty;
            end
            // cnt is 0 in the enable cycle, so reaching MEM_LATENCY lines up
            // with the cycle the BRAM presents the data.
            ST_WAIT: begin
                if (cnt_q == CNT_MAX) begin
                    state_d     = ST_HOLD;
                    cdb_valid_d = 1'b1;
                    cdb_tag_d   = act_tag_q;
                    cdb_data_d  = extract_load(mem_rdata_in, act_off_q, act_f3_q);
`ifdef LOAD_MISALIGN_CHECK_EN
                    cdb_exc_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cdb_ready_in) begin
                    cdb_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    issue       = !empty;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pop the head; the pop does not free a slot for this cycle's request
        // because req_ready_out is decoded from the current pointers.
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
`ifdef LOAD_MISALIGN_CHECK_EN
            if (is_misaligned(head_addr[1:0], head_f3)) begin
                state_d     = ST_HOLD;
                cdb_valid_d = 1'b1;
                cdb_tag_d   = head_tag;
                cdb_data_d  = 32'd0;
                cdb_exc_d   = 1'b1;
            end else
`endif
            begin
                state_d    = ST_WAIT;
                mem_en_d   = 1'b1;
                mem_addr_d = head_addr[31:2];
                cnt_d      = '0;
                act_off_d  = head_addr[1:0];
                act_f3_d   = head_f3;
                act_tag_d  = head_tag;
            end
        end

        // Flush overrides everything; leaving WAIT discards in-flight data.
        if (flush_in) begin
            state_d     = ST_IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            mem_en_d    = 1'b0;
            cdb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            act_off_q   <= '0;
            act_f3_q    <= '0;
            act_tag_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
`ifdef LOAD_MISALIGN_CHECK_EN
            cdb_exc_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            act_off_q   <= act_off_d;
            act_f3_q    <= act_f3_d;
            act_tag_q   <= act_tag_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
`ifdef LOAD_MISALIGN_CHECK_EN
            cdb_exc_q   <= cdb_exc_d;
`endif
        end
    end

    assign req_ready_out = !full;
    assign mem_en_out    = mem_en_q;
    assign mem_addr_out  = mem_addr_q;
    assign cdb_valid_out = cdb_valid_q;
    assign cdb_tag_out   = cdb_tag_q;
    assign cdb_data_out  = cdb_data_q;
`ifdef LOAD_MISALIGN_CHECK_EN
    assign cdb_exc_out   = cdb_exc_q;
`else
    assign cdb_exc_out   = 1'b0;
`endif

endmodule

// File: tb/tb_load_queue.sv
module tb_load_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int ML    = 2;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic [2:0]       req_funct3;
    logic [TAG_W-1:0] req_tag;
    logic             mem_en;
    logic [29:0]      mem_addr;
    logic [31:0]      mem_rdata;
    logic             cdb_valid;
    logic             cdb_ready;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             cdb_exc;

    load_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .MEM_LATENCY(ML)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush),
        .req_valid_in(req_valid), .req_ready_out(req_ready),
        .req_addr_in(req_addr), .req_funct3_in(req_funct3), .req_tag_in(req_tag),
        .mem_en_out(mem_en), .mem_addr_out(mem_addr), .mem_rdata_in(mem_rdata),
        .cdb_valid_out(cdb_valid), .cdb_ready_in(cdb_ready),
        .cdb_tag_out(cdb_tag), .cdb_data_out(cdb_data), .cdb_exc_out(cdb_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: data is valid exactly ML cycles after the enable cycle,
    // garbage otherwise so a mistimed capture shows up.
    logic [31:0] mem [0:63];
    logic [31:0] rd_pipe [0:ML-1];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_en ? mem[mem_addr[5:0]] : 32'hDEAD_BEEF;
        for (int i = 1; i < ML; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[ML-1];

    int          mem_en_cnt = 0;
    logic [29:0] last_mem_addr = '0;
    always @(negedge clk) begin
        if (rst_n && mem_en) begin
            mem_en_cnt    <= mem_en_cnt + 1;
            last_mem_addr <= mem_addr;
        end
    end

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             exc;
    } exp_t;
    exp_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [2:0] F_LB = 3'b000, F_LH = 3'b001, F_LW = 3'b010,
                           F_LBU = 3'b100, F_LHU = 3'b101, F_RSV = 3'b011;

    task automatic do_req(input logic [31:0] a, input logic [2:0] f3,
                          input logic [TAG_W-1:0] t, output int acc, output logic ok);
        logic r;
        req_addr = a; req_funct3 = f3; req_tag = t; req_valid = 1'b1;
        ok = 1'b0; acc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            r = req_ready;
            @(posedge clk); #1;
            if (r) begin ok = 1'b1; acc = cyc; break; end
        end
        req_valid = 1'b0;
    endtask

    // Waits for a CDB handshake and returns what was observed.
    task automatic collect(input int budget, output logic ok, output logic [TAG_W-1:0] t,
                           output logic [31:0] d, output logic x, output int at);
        ok = 1'b0; t = '0; d = '0; x = 1'b0; at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cdb_valid && cdb_ready) begin
                ok = 1'b1; t = cdb_tag; d = cdb_data; x = cdb_exc; at = cyc;
                @(posedge clk); #1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({mem_en, mem_addr, cdb_valid, cdb_tag, cdb_data, cdb_exc, req_ready} !==
            {1'b0, 30'd0, 1'b0, {TAG_W{1'b0}}, 32'd0, 1'b0, 1'b1})
            $display("FAIL reset_state: got en=%b addr=%h v=%b tag=%h data=%h exc=%b rdy=%b, required all 0 and rdy=1",
                     mem_en, mem_addr, cdb_valid, cdb_tag, cdb_data, cdb_exc, req_ready);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_extract();
        logic [31:0]      addrs [5] = '{32'h10, 32'h12, 32'h13, 32'h12, 32'h10};
        logic [2:0]       f3s   [5] = '{F_LB, F_LB, F_LBU, F_LH, F_LHU};
        logic [31:0]      dats  [5] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0080,
                                         32'hFFFF_80FF, 32'h0000_7F01};
        exp_t e; int acc; int at; int en0; logic ok, gok, x;
        logic [TAG_W-1:0] t; logic [31:0] d;
        cdb_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            en0 = mem_en_cnt;
            exp_q.push_back('{tag: TAG_W'(k + 1), data: dats[k], exc: 1'b0});
            do_req(addrs[k], f3s[k], TAG_W'(k + 1), acc, ok);
            collect(30, gok, t, d, x, at);
            e = exp_q.pop_front();
            n_total++;
            if (!gok || t !== e.tag || d !== e.data || x !== e.exc)
                $display("FAIL extract_%0d: got ok=%b tag=%h data=%h exc=%b, required tag=%h data=%h exc=%b",
                         k, gok, t, d, x, e.tag, e.data, e.exc);
            else n_pass++;
            n_total++;
            if (!ok || at - acc != ML + 2)
                $display("FAIL latency_%0d: got %0d cycles, required %0d", k, at - acc, ML + 2);
            else n_pass++;
            n_total++;
            if (mem_en_cnt != en0 + 1 || last_mem_addr !== 30'd4)
                $display("FAIL mem_en_%0d: got pulses=%0d addr=%h, required pulses=1 addr=4",
                         k, mem_en_cnt - en0, last_mem_addr);
            else n_pass++;
        end
    endtask

    task automatic test_hold_stable();
        exp_t e; int acc; int at; logic ok, gok, x, stable, seen;
        logic [TAG_W-1:0] t; logic [31:0] d;
        logic [TAG_W+32:0] snap;
        cdb_ready = 1'b0;
        exp_q.push_back('{tag: TAG_W'(9), data: 32'hFFFF_80FF, exc: 1'b0});
        do_req(32'h12, F_LH, TAG_W'(9), acc, ok);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = cdb_valid; end
        snap = {cdb_tag, cdb_data, cdb_exc};
        stable = seen;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!cdb_valid || {cdb_tag, cdb_data, cdb_exc} !== snap) stable = 1'b0;
        end
        n_total++;
        if (!stable) $display("FAIL hold_stable: got valid=%b tag=%h data=%h, required stable tag=9 data=ffff80ff",
                              cdb_valid, cdb_tag, cdb_data);
        else n_pass++;
        @(posedge clk); #1;
        cdb_ready = 1'b1;
        collect(1, gok, t, d, x, at);
        e = exp_q.pop_front();
        n_total++;
        if (!gok || t !== e.tag || d !== e.data || x !== e.exc)
            $display("FAIL hold_grant: got ok=%b tag=%h data=%h exc=%b, required tag=%h data=%h exc=%b",
                     gok, t, d, x, e.tag, e.data, e.exc);
        else n_pass++;
        n_total++;
        if (cdb_valid !== 1'b0) $display("FAIL hold_release: got valid=%b, required 0", cdb_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e; int acc; logic ok, seen, stuck, pending, r;
        cdb_ready = 1'b0;
        exp_q.push_back('{tag: TAG_W'(1), data: mem[5], exc: 1'b0});
        do_req(32'h14, F_LW, TAG_W'(1), acc, ok);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = cdb_valid; end
        @(posedge clk); #1;
        for (int k = 0; k < DEPTH; k++) begin
            exp_q.push_back('{tag: TAG_W'(2 + k), data: mem[6 + k], exc: 1'b0});
            do_req(32'((6 + k) * 4), F_LW, TAG_W'(2 + k), acc, ok);
        end
        n_total++;
        if (req_ready !== 1'b0) $display("FAIL full_ready: got %b, required 0", req_ready);
        else n_pass++;
        req_addr = 32'((6 + DEPTH) * 4); req_funct3 = F_LW; req_tag = TAG_W'(2 + DEPTH);
        req_valid = 1'b1;
        stuck = 1'b1;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (req_ready) stuck = 1'b0; end
        n_total++;
        if (!stuck) $display("FAIL full_stall: got ready=1 while full, required 0");
        else n_pass++;
        exp_q.push_back('{tag: TAG_W'(2 + DEPTH), data: mem[6 + DEPTH], exc: 1'b0});
        @(posedge clk); #1;
        cdb_ready = 1'b1;
        pending = 1'b1;
        for (int i = 0; i < 200 && (pending || exp_q.size() != 0); i++) begin
            @(negedge clk);
            r = req_ready;
            if (cdb_valid) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL drain_extra: got tag=%h with nothing outstanding, required none", cdb_tag);
                end else begin
                    e = exp_q.pop_front();
                    if (cdb_tag !== e.tag || cdb_data !== e.data || cdb_exc !== e.exc)
                        $display("FAIL drain_order: got tag=%h data=%h exc=%b, required tag=%h data=%h exc=%b",
                                 cdb_tag, cdb_data, cdb_exc, e.tag, e.data, e.exc);
                    else n_pass++;
                end
            end
            @(posedge clk); #1;
            if (pending && r) begin pending = 1'b0; req_valid = 1'b0; end
        end
        req_valid = 1'b0;
        n_total++;
        if (pending || exp_q.size() != 0)
            $display("FAIL drain_timeout: got pending=%b left=%0d, required 0 and 0", pending, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_flush();
        exp_t e; int acc; int at; int en0; logic ok, gok, x, quiet;
        logic [TAG_W-1:0] t; logic [31:0] d;
        cdb_ready = 1'b1;
        for (int k = 0; k < 4; k++) do_req(32'((6 + k) * 4), F_LW, TAG_W'(1 + k), acc, ok);
        // One load in WAIT, three queued; a request in the flush cycle is dropped.
        flush = 1'b1;
        req_addr = 32'h10; req_funct3 = F_LW; req_tag = 4'hF; req_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        n_total++;
        if (cdb_valid !== 1'b0 || mem_en !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL flush_state: got valid=%b en=%b ready=%b, required 0 0 1", cdb_valid, mem_en, req_ready);
        else n_pass++;
        en0 = mem_en_cnt;
        quiet = 1'b1;
        for (int i = 0; i < 15; i++) begin @(negedge clk); if (cdb_valid) quiet = 1'b0; end
        n_total++;
        if (!quiet || mem_en_cnt != en0)
            $display("FAIL flush_quiet: got cdb_seen=%b mem_en_pulses=%0d, required 0 and 0",
                     !quiet, mem_en_cnt - en0);
        else n_pass++;
        @(posedge clk); #1;
        exp_q.push_back('{tag: TAG_W'(5), data: 32'h80FF_7F01, exc: 1'b0});
        do_req(32'h10, F_LW, TAG_W'(5), acc, ok);
        collect(30, gok, t, d, x, at);
        e = exp_q.pop_front();
        n_total++;
        if (!gok || t !== e.tag || d !== e.data || x !== e.exc)
            $display("FAIL post_flush: got ok=%b tag=%h data=%h exc=%b, required tag=%h data=%h exc=%b",
                     gok, t, d, x, e.tag, e.data, e.exc);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int acc; logic ok, held;
        do_req(32'h14, F_LW, TAG_W'(6), acc, ok);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({mem_en, mem_addr, cdb_valid, cdb_tag, cdb_data, cdb_exc, req_ready} !==
            {1'b0, 30'd0, 1'b0, {TAG_W{1'b0}}, 32'd0, 1'b0, 1'b1})
            $display("FAIL async_reset: got en=%b addr=%h v=%b tag=%h data=%h exc=%b rdy=%b, required all 0 and rdy=1",
                     mem_en, mem_addr, cdb_valid, cdb_tag, cdb_data, cdb_exc, req_ready);
        else n_pass++;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ({mem_en, mem_addr, cdb_valid, cdb_tag, cdb_data, cdb_exc} !== '0) held = 1'b0;
        end
        n_total++;
        if (!held) $display("FAIL reset_hold: got en=%b addr=%h v=%b data=%h, required all 0",
                            mem_en, mem_addr, cdb_valid, cdb_data);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_misalign();
        logic [31:0] addrs [2] = '{32'h11, 32'h10};
        logic [2:0]  f3s   [2] = '{F_LW, F_RSV};
        exp_t e; int acc; int at; int en0; int lat; int pulses; logic ok, gok, x;
        logic [TAG_W-1:0] t; logic [31:0] d;
        cdb_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            en0 = mem_en_cnt;
`ifdef LOAD_MISALIGN_CHECK_EN
            exp_q.push_back('{tag: TAG_W'(7 + k), data: 32'd0, exc: 1'b1});
            lat = 1; pulses = 0;
`else
            exp_q.push_back('{tag: TAG_W'(7 + k), data: 32'h80FF_7F01, exc: 1'b0});
            lat = ML + 2; pulses = 1;
`endif
            do_req(addrs[k], f3s[k], TAG_W'(7 + k), acc, ok);
            collect(30, gok, t, d, x, at);
            e = exp_q.pop_front();
            n_total++;
            if (!gok || t !== e.tag || d !== e.data || x !== e.exc)
                $display("FAIL misalign_%0d: got ok=%b tag=%h data=%h exc=%b, required tag=%h data=%h exc=%b",
                         k, gok, t, d, x, e.tag, e.data, e.exc);
            else n_pass++;
            n_total++;
            if (!ok || at - acc != lat || mem_en_cnt - en0 != pulses)
                $display("FAIL misalign_path_%0d: got lat=%0d pulses=%0d, required lat=%0d pulses=%0d",
                         k, at - acc, mem_en_cnt - en0, lat, pulses);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 32'h0101);
        mem[4] = 32'h80FF_7F01;
        rst_n = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0;
        req_funct3 = '0; req_tag = '0; cdb_ready = 1'b1;
        #2 rst_n = 1'b0;

        test_reset();
        test_extract();
        test_hold_stable();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_misalign();

        n_total++;
        if (exp_q.size() != 0) $display("FAIL leftover: got %0d outstanding results, required 0", exp_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
